// File: rtl/regset_arbiter_pkg.sv
// Shared pipeline definitions for the register-set arbiter: geometry of the
// 64x32 register set and the arbiter state encoding.
package regset_arbiter_pkg;

    localparam int REGSET_DEPTH = 64;
    localparam int ADDR_W       = $clog2(REGSET_DEPTH);
    localparam int DATA_W       = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_INIT     = 3'd0;
    localparam state_t ST_RUN      = 3'd1;
    localparam state_t ST_RD_ADDR  = 3'd2;
    localparam state_t ST_RD_DATA  = 3'd3;
    localparam state_t ST_WR_FORCE = 3'd4;

endpackage

// File: rtl/regset_arbiter.sv
// Arbitrates the 64x32 register set between the pipeline and a debug port,
// scrubbing the set to zero after reset and bounding debug-write starvation.
module regset_arbiter
    import regset_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_wa,
    input  logic [DATA_W-1:0] pipe_wd,
    input  logic [ADDR_W-1:0] pipe_ra1,
    input  logic [ADDR_W-1:0] pipe_ra2,
    output logic [DATA_W-1:0] pipe_rd1,
    output logic [DATA_W-1:0] pipe_rd2,
    output logic              pipe_stall,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              init_done,

    output logic              rs_we,
    output logic [ADDR_W-1:0] rs_wa,
    output logic [DATA_W-1:0] rs_wd,
    output logic [ADDR_W-1:0] rs_ra1,
    output logic [ADDR_W-1:0] rs_ra2,
    input  logic [DATA_W-1:0] rs_rd1,
    input  logic [DATA_W-1:0] rs_rd2
);

    localparam int                STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] SCRUB_LAST = ADDR_W'(REGSET_DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   scrub_q, scrub_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                init_done_q, init_done_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                we_int;

    assign pipe_rd1  = rs_rd1;
    assign pipe_rd2  = rs_rd2;
    assign init_done = init_done_q;

    // The scrub drives a write from the INIT state, so the write strobe is
    // masked directly by reset to keep the set untouched while rstn is low.
    assign rs_we = we_int & rstn;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        scrub_d     = scrub_q;
        starve_d    = starve_q;
        init_done_d = init_done_q;
        dbg_rdata_d = dbg_rdata_q;
        we_int      = pipe_we;
        rs_wa       = pipe_wa;
        rs_wd       = pipe_wd;
        rs_ra1      = pipe_ra1;
        rs_ra2      = pipe_ra2;
        pipe_stall  = 1'b1;
        dbg_ack     = 1'b0;
        dbg_rdata   = dbg_rdata_q;

        case (state_q)
            ST_INIT: begin
                we_int = 1'b1;
                rs_wa  = scrub_q;
                rs_wd  = '0;
                if (scrub_q == SCRUB_LAST) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    scrub_d = scrub_q + 1'b1;
                end
            end

            ST_RUN: begin
                pipe_stall = 1'b0;
                if (dbg_req && !dbg_we) begin
                    state_d = ST_RD_ADDR;
                end else if (dbg_req && !pipe_we) begin
                    we_int   = 1'b1;
                    rs_wa    = dbg_addr;
                    rs_wd    = dbg_wdata;
                    dbg_ack  = 1'b1;
                    starve_d = '0;
                end else if (dbg_req) begin
                    // Pipeline keeps the port; after STARVE_MAX refusals the
                    // debug write is forced through with the pipeline stalled.
                    starve_d = starve_q + 1'b1;
                    if (starve_d == STARVE_W'(STARVE_MAX)) begin
                        state_d = ST_WR_FORCE;
                    end
                end
            end

            ST_RD_ADDR: begin
                rs_ra2  = dbg_addr;
                state_d = ST_RD_DATA;
            end

            ST_RD_DATA: begin
                dbg_ack     = 1'b1;
                dbg_rdata   = rs_rd2;
                dbg_rdata_d = rs_rd2;
                state_d     = ST_RUN;
            end

            ST_WR_FORCE: begin
                we_int   = 1'b1;
                rs_wa    = dbg_addr;
                rs_wd    = dbg_wdata;
                dbg_ack  = 1'b1;
                starve_d = '0;
                state_d  = ST_RUN;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_INIT;
            scrub_q     <= ADDR_W'(1);
            starve_q    <= '0;
            init_done_q <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            scrub_q     <= scrub_d;
            starve_q    <= starve_d;
            init_done_q <= init_done_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_regset_arbiter.sv
// Self-checking bench for regset_arbiter: a behavioural register set plus a
// transaction-level reference model driven by randomized pipeline/debug traffic.
module tb_regset_arbiter;

    localparam int STARVE_MAX = 8;
    localparam int DEPTH      = 64;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pipe_we;
    logic [5:0]  pipe_wa, pipe_ra1, pipe_ra2;
    logic [31:0] pipe_wd, pipe_rd1, pipe_rd2;
    logic        pipe_stall;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic        init_done;
    logic        rs_we;
    logic [5:0]  rs_wa, rs_ra1, rs_ra2;
    logic [31:0] rs_wd, rs_rd1, rs_rd2;

    always #5 clk = ~clk;

    regset_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rstn(rstn),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .pipe_ra1(pipe_ra1), .pipe_ra2(pipe_ra2),
        .pipe_rd1(pipe_rd1), .pipe_rd2(pipe_rd2), .pipe_stall(pipe_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .init_done(init_done),
        .rs_we(rs_we), .rs_wa(rs_wa), .rs_wd(rs_wd),
        .rs_ra1(rs_ra1), .rs_ra2(rs_ra2), .rs_rd1(rs_rd1), .rs_rd2(rs_rd2)
    );

    // Register set: 1-cycle synchronous read (old data on collision), address 0 reads 0.
    logic [31:0] mem [DEPTH];
    logic [31:0] seed_mem [DEPTH];
    logic        preload_en;

    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= seed_mem[i];
        end else if (rs_we && rs_wa != 6'd0) begin
            mem[rs_wa] <= rs_wd;
        end
        rs_rd1 <= (rs_ra1 == 6'd0) ? 32'h0 : mem[rs_ra1];
        rs_rd2 <= (rs_ra2 == 6'd0) ? 32'h0 : mem[rs_ra2];
    end

    // Reference model state
    logic [31:0] exp_mem [DEPTH];
    int          scrub_left, rd_phase, refusals;
    bit          force_pend, exp_init_done, prev_valid;
    logic [31:0] exp_rdata, rd_snap, nx_rd1, nx_rd2;
    bit          m_stall, m_ack;

    // Observations of the most recent cycle
    bit          obs_stall, obs_ack, obs_we;
    logic [5:0]  obs_wa;
    logic [31:0] obs_wd, obs_rdata;

    // Stimulus knobs
    typedef struct packed {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] data;
    } dreq_t;
    dreq_t dbg_q [$];
    int    we_pct, dbg_pct;
    logic  rstn_nx;

    int n_cmp, n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, got, want);
        end
    endtask

    function automatic logic [31:0] rdval(input logic [5:0] a);
        return (a == 6'd0) ? 32'h0 : exp_mem[a];
    endfunction

    task automatic model_reset();
        scrub_left    = DEPTH - 1;
        rd_phase      = 0;
        refusals      = 0;
        force_pend    = 1'b0;
        exp_init_done = 1'b0;
        exp_rdata     = 32'h0;
        prev_valid    = 1'b0;
        m_stall       = 1'b1;
        m_ack         = 1'b0;
    endtask

    // Pipeline advances only when it was not stalled; debug requester holds until ack.
    task automatic gen_inputs();
        dreq_t r;
        if (!m_stall) begin
            pipe_we  = ($urandom_range(99) < we_pct);
            pipe_wa  = 6'($urandom_range(63));
            pipe_wd  = $urandom;
            pipe_ra1 = 6'($urandom_range(63));
            pipe_ra2 = 6'($urandom_range(63));
        end
        if (m_ack || !dbg_req) begin
            if (dbg_q.size() > 0) begin
                r = dbg_q.pop_front();
                dbg_req = 1'b1; dbg_we = r.we; dbg_addr = r.addr; dbg_wdata = r.data;
            end else if ($urandom_range(99) < dbg_pct) begin
                dbg_req   = 1'b1;
                dbg_we    = 1'($urandom_range(1));
                dbg_addr  = 6'($urandom_range(63));
                dbg_wdata = $urandom;
            end else begin
                dbg_req = 1'b0;
            end
        end
    endtask

    task automatic evaluate();
        bit          e_stall, e_ack, e_we, done_now;
        logic [5:0]  e_wa;
        logic [31:0] e_wd;
        int          phase0;
        obs_stall = pipe_stall; obs_ack = dbg_ack; obs_we = rs_we;
        obs_wa = rs_wa; obs_wd = rs_wd; obs_rdata = dbg_rdata;
        if (!rstn) begin
            check("rst_rs_we", rs_we, 0);
            check("rst_stall", pipe_stall, 1);
            check("rst_init_done", init_done, 0);
            check("rst_ack", dbg_ack, 0);
            check("rst_rdata", dbg_rdata, 0);
            model_reset();
            return;
        end
        e_stall = 1'b0; e_ack = 1'b0; e_we = pipe_we; e_wa = pipe_wa; e_wd = pipe_wd;
        done_now = 1'b0; phase0 = rd_phase;
        if (scrub_left > 0) begin
            e_stall = 1'b1; e_we = 1'b1; e_wa = 6'(DEPTH - scrub_left); e_wd = 32'h0;
            scrub_left--;
            done_now = (scrub_left == 0);
        end else if (rd_phase == 1) begin
            e_stall = 1'b1; rd_snap = rdval(dbg_addr); rd_phase = 2;
        end else if (rd_phase == 2) begin
            e_stall = 1'b1; e_ack = 1'b1; exp_rdata = rd_snap; rd_phase = 0;
        end else if (force_pend) begin
            e_stall = 1'b1; e_ack = 1'b1; e_we = 1'b1; e_wa = dbg_addr; e_wd = dbg_wdata;
            force_pend = 1'b0; refusals = 0;
        end else if (dbg_req && !dbg_we) begin
            rd_phase = 1;
        end else if (dbg_req && !pipe_we) begin
            e_ack = 1'b1; e_we = 1'b1; e_wa = dbg_addr; e_wd = dbg_wdata; refusals = 0;
        end else if (dbg_req) begin
            refusals++;
            if (refusals == STARVE_MAX) force_pend = 1'b1;
        end

        check("stall", pipe_stall, e_stall);
        check("ack", dbg_ack, e_ack);
        check("init_done", init_done, exp_init_done);
        check("rs_we", rs_we, e_we);
        if (e_we) begin
            check("rs_wa", rs_wa, e_wa);
            check("rs_wd", rs_wd, e_wd);
        end
        check("dbg_rdata", dbg_rdata, exp_rdata);
        if (prev_valid && !e_stall) begin
            check("pipe_rd1", pipe_rd1, nx_rd1);
            check("pipe_rd2", pipe_rd2, nx_rd2);
        end

        nx_rd1 = rdval(pipe_ra1);
        nx_rd2 = (phase0 == 1) ? rdval(dbg_addr) : rdval(pipe_ra2);
        if (e_we && e_wa != 6'd0) exp_mem[e_wa] = e_wd;
        if (done_now) exp_init_done = 1'b1;
        prev_valid = 1'b1;
        m_stall = e_stall;
        m_ack   = e_ack;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rstn = rstn_nx;
        gen_inputs();
        @(negedge clk);
        evaluate();
    endtask

    task automatic wait_ack(input string tag, input int limit, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!obs_ack && cycles < limit);
        check(tag, obs_ack, 1);
    endtask

    task automatic drain();
        int n;
        dbg_pct = 0; we_pct = 0; n = 0;
        while (dbg_req && n < 200) begin
            step();
            n++;
        end
        check("drain_idle", dbg_req, 0);
    endtask

    initial begin
        int cnt;
        n_cmp = 0; n_err = 0;
        for (int i = 0; i < DEPTH; i++) begin
            seed_mem[i] = (i == 0) ? 32'h0 : $urandom;
            exp_mem[i]  = seed_mem[i];
        end
        preload_en = 1'b1;
        rstn = 1'b1; rstn_nx = 1'b0;
        pipe_we = 1'b0; pipe_wa = '0; pipe_wd = '0; pipe_ra1 = 6'd1; pipe_ra2 = 6'd2;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        we_pct = 0; dbg_pct = 0;
        model_reset();
        #2 rstn = 1'b0;
        @(posedge clk);
        #1 preload_en = 1'b0;

        // Reset, with a debug write already waiting through the scrub.
        dbg_q.push_back('{we: 1'b1, addr: 6'd7, data: 32'h1234_5678});
        repeat (3) step();
        rstn_nx = 1'b1;
        step();
        check("scrub_first_wa", obs_wa, 1);
        cnt = 1;
        while (!obs_ack && cnt < 100) begin
            step();
            cnt++;
        end
        check("init_ack_cycle", cnt, 64);
        check("first_run_stall", obs_stall, 0);

        // Debug read of a known value: two stall cycles, ack on the second.
        dbg_q.push_back('{we: 1'b1, addr: 6'd5, data: 32'hDEAD_BEEF});
        wait_ack("wr5_ack", 20, cnt);
        check("wr5_same_cycle", cnt, 1);
        dbg_q.push_back('{we: 1'b0, addr: 6'd5, data: 32'h0});
        step();
        check("rd5_accept_stall", obs_stall, 0);
        step();
        check("rd5_addr_stall", obs_stall, 1);
        check("rd5_addr_ack", obs_ack, 0);
        step();
        check("rd5_data_stall", obs_stall, 1);
        check("rd5_data_ack", obs_ack, 1);
        check("rd5_data", obs_rdata, 32'hDEAD_BEEF);
        step();
        check("rd5_after_stall", obs_stall, 0);

        dbg_q.push_back('{we: 1'b0, addr: 6'd7, data: 32'h0});
        wait_ack("rd7_ack", 20, cnt);
        check("rd7_data", obs_rdata, 32'h1234_5678);
        dbg_q.push_back('{we: 1'b0, addr: 6'd0, data: 32'h0});
        wait_ack("rd0_ack", 20, cnt);
        check("rd0_data", obs_rdata, 32'h0);

        // Starvation: pipeline writes every cycle, debug write forced on the 9th.
        we_pct = 100;
        step();
        dbg_q.push_back('{we: 1'b1, addr: 6'd9, data: 32'hA5A5_0F0F});
        for (int i = 0; i < STARVE_MAX; i++) begin
            step();
            check("starve_refused", {obs_ack, obs_stall}, 2'b00);
        end
        step();
        check("force_stall", obs_stall, 1);
        check("force_ack", obs_ack, 1);
        check("force_we", obs_we, 1);
        check("force_wa", obs_wa, 9);
        check("force_wd", obs_wd, 32'hA5A5_0F0F);

        // Randomized traffic.
        we_pct = 50; dbg_pct = 30;
        repeat (3000) step();
        drain();

        // Reset mid-scrub at address 30 with a debug write pending.
        rstn_nx = 1'b0;
        repeat (2) step();
        dbg_q.push_back('{we: 1'b1, addr: 6'd11, data: 32'hCAFE_F00D});
        rstn_nx = 1'b1;
        step();
        cnt = 0;
        while (scrub_left != DEPTH - 30 && cnt < 100) begin
            step();
            cnt++;
        end
        rstn_nx = 1'b0;
        step();
        step();
        rstn_nx = 1'b1;
        step();
        check("rescrub_first_wa", obs_wa, 1);
        check("rescrub_init_done", init_done, 0);
        cnt = 1;
        while (!obs_ack && cnt < 100) begin
            step();
            cnt++;
        end
        check("rescrub_ack_cycle", cnt, 64);

        // Reset in the middle of a debug read: the held read is replayed after scrub.
        dbg_q.push_back('{we: 1'b0, addr: 6'd11, data: 32'h0});
        step();
        step();
        rstn_nx = 1'b0;
        step();
        rstn_nx = 1'b1;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!obs_ack && cnt < 100);
        check("abort_read_ack_cycle", cnt, 66);
        check("abort_read_scrubbed", obs_rdata, 32'h0);

        we_pct = 40; dbg_pct = 40;
        repeat (500) step();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
